// File: rtl/ctr_block_sequencer.sv
// CTR-mode keystream sequencer: owns session key and block counter, launches AES with {IV, counter}.
// Optional NONCE_TIMEOUT_EN macro bounds the AES wait and pulses err on abort.
module ctr_block_sequencer #(
  parameter logic [63:0] IV      = 64'hba23890ace346bf1,
  parameter int          CTR_W   = 64,
  parameter int          TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [127:0]     key_in,
  output logic             key_ready,
  input  logic             blk_req,
  output logic             blk_gnt,
  output logic             aes_start,
  output logic [127:0]     aes_nonce,
  input  logic             aes_done,
  input  logic [127:0]     aes_dout,
  output logic             ks_valid,
  output logic [127:0]     ks_data,
  input  logic             ks_ready,
  output logic [CTR_W-1:0] ctr_value,
  output logic             exhausted,
  output logic             err
);

  localparam int           PFX_W  = 128 - CTR_W;
  localparam logic [127:0] IV_EXT = {64'd0, IV};

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [127:0]       key_q;
  logic               key_loaded;
  logic [CTR_W-1:0]   counter;
  logic [PFX_W-1:0]   iv_pfx;
  logic               key_load;
  logic               done_take;

  assign iv_pfx    = IV_EXT[PFX_W-1:0];
  assign ctr_value = counter;
  assign aes_start = (state == START);

`ifdef NONCE_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            timeout;
`endif

  always_comb begin
    state_nxt = state;
    blk_gnt   = 1'b0;
    key_load  = 1'b0;
    done_take = 1'b0;
`ifdef NONCE_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Key loads win over block requests; key_ready is low the first cycle out of reset.
        if (key_valid && key_ready) begin
          key_load = 1'b1;
        end else if (blk_req && !key_valid && key_loaded && !exhausted) begin
          blk_gnt   = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (aes_done) begin
          done_take = 1'b1;
          state_nxt = HOLD;
        end
`ifdef NONCE_TIMEOUT_EN
        else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      HOLD: if (ks_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      key_ready  <= 1'b0;
      key_q      <= '0;
      key_loaded <= 1'b0;
      counter    <= '0;
      exhausted  <= 1'b0;
      aes_nonce  <= '0;
      ks_valid   <= 1'b0;
      ks_data    <= '0;
    end else begin
      state     <= state_nxt;
      key_ready <= (state_nxt == IDLE);
      if (key_load && (!key_loaded || key_in != key_q)) begin
        key_q      <= key_in;
        key_loaded <= 1'b1;
        counter    <= '0;
        exhausted  <= 1'b0;
      end
      if (blk_gnt) aes_nonce <= {iv_pfx, counter};
      // Counter advances only on completion so an aborted nonce is reissued.
      if (done_take) begin
        ks_data  <= aes_dout;
        ks_valid <= 1'b1;
        if (&counter) exhausted <= 1'b1;
        else          counter   <= counter + CTR_W'(1);
      end
      if (state == HOLD && ks_ready) ks_valid <= 1'b0;
    end
  end

`ifdef NONCE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err      <= timeout;
      wait_cnt <= (state == WAIT) ? wait_cnt + WC_W'(1) : '0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ctr_block_sequencer.sv
// Randomized bench: a 64-bit and a 4-bit counter instance share stimulus via sel, checked against a queue-free counter model.
module tb_ctr_block_sequencer;
  localparam logic [63:0] IV = 64'hba23890ace346bf1;
  localparam int TO = 8;
`ifdef NONCE_TIMEOUT_EN
  localparam int MAXD = 6;
`else
  localparam int MAXD = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sel, key_valid, blk_req, aes_done, ks_ready;
  logic [127:0] key_in, aes_dout;

  logic w_key_ready, w_blk_gnt, w_aes_start, w_ks_valid, w_exh, w_err;
  logic [127:0] w_aes_nonce, w_ks_data;
  logic [63:0] w_ctr;
  logic n_key_ready, n_blk_gnt, n_aes_start, n_ks_valid, n_exh, n_err;
  logic [127:0] n_aes_nonce, n_ks_data;
  logic [3:0] n_ctr;

  ctr_block_sequencer #(.IV(IV), .CTR_W(64), .TIMEOUT(TO)) u_wide (
    .clk(clk), .reset(reset),
    .key_valid(key_valid & ~sel), .key_in(key_in), .key_ready(w_key_ready),
    .blk_req(blk_req & ~sel), .blk_gnt(w_blk_gnt),
    .aes_start(w_aes_start), .aes_nonce(w_aes_nonce),
    .aes_done(aes_done & ~sel), .aes_dout(aes_dout),
    .ks_valid(w_ks_valid), .ks_data(w_ks_data), .ks_ready(ks_ready & ~sel),
    .ctr_value(w_ctr), .exhausted(w_exh), .err(w_err));

  ctr_block_sequencer #(.IV(IV), .CTR_W(4), .TIMEOUT(TO)) u_narrow (
    .clk(clk), .reset(reset),
    .key_valid(key_valid & sel), .key_in(key_in), .key_ready(n_key_ready),
    .blk_req(blk_req & sel), .blk_gnt(n_blk_gnt),
    .aes_start(n_aes_start), .aes_nonce(n_aes_nonce),
    .aes_done(aes_done & sel), .aes_dout(aes_dout),
    .ks_valid(n_ks_valid), .ks_data(n_ks_data), .ks_ready(ks_ready & sel),
    .ctr_value(n_ctr), .exhausted(n_exh), .err(n_err));

  logic o_key_ready, o_blk_gnt, o_aes_start, o_ks_valid, o_exh, o_err;
  logic [127:0] o_aes_nonce, o_ks_data;
  logic [63:0] o_ctr;
  assign o_key_ready = sel ? n_key_ready : w_key_ready;
  assign o_blk_gnt   = sel ? n_blk_gnt   : w_blk_gnt;
  assign o_aes_start = sel ? n_aes_start : w_aes_start;
  assign o_ks_valid  = sel ? n_ks_valid  : w_ks_valid;
  assign o_exh       = sel ? n_exh       : w_exh;
  assign o_err       = sel ? n_err       : w_err;
  assign o_aes_nonce = sel ? n_aes_nonce : w_aes_nonce;
  assign o_ks_data   = sel ? n_ks_data   : w_ks_data;
  assign o_ctr       = sel ? {60'd0, n_ctr} : w_ctr;

  // Reference model, one slot per instance: key policy and counter arithmetic only.
  logic [127:0] m_key [2];
  bit           m_loaded [2];
  logic [63:0]  m_ctr [2];
  bit           m_exh [2];
  int total = 0;
  int bad = 0;

  function automatic logic [63:0] m_max();
    return sel ? 64'hF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [127:0] exp_nonce();
    logic [63:0] c;
    c = m_ctr[sel];
    return sel ? {60'd0, IV, c[3:0]} : {IV, c};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_key[i] = '0; m_loaded[i] = 0; m_ctr[i] = '0; m_exh[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; key_valid = 0; blk_req = 0; aes_done = 0; ks_ready = 0;
    key_in = '0; aes_dout = '0; sel = 0;
    #3;
    total++;
    if ({w_key_ready, w_blk_gnt, w_aes_start, w_aes_nonce, w_ks_valid, w_ks_data, w_ctr, w_exh, w_err} !== '0) begin
      bad++; $display("FAIL reset_wide_outputs got nonzero nonce=%h ctr=%h", w_aes_nonce, w_ctr);
    end
    total++;
    if ({n_key_ready, n_blk_gnt, n_aes_start, n_aes_nonce, n_ks_valid, n_ks_data, n_ctr, n_exh, n_err} !== '0) begin
      bad++; $display("FAIL reset_narrow_outputs got nonzero nonce=%h ctr=%h", n_aes_nonce, n_ctr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    tick();
    @(negedge clk);
    total++;
    if (o_key_ready !== 1'b1) begin
      bad++; $display("FAIL reset_key_ready got=%b exp=1", o_key_ready);
    end
    tick();
  endtask

  task automatic load_key(input logic [127:0] k);
    key_valid = 1; key_in = k; blk_req = 1'($urandom);
    @(negedge clk);
    total++;
    if (o_key_ready !== 1'b1 || o_blk_gnt !== 1'b0) begin
      bad++; $display("FAIL key_cycle ready/gnt got=%b%b exp=10", o_key_ready, o_blk_gnt);
    end
    tick();
    key_valid = 0; blk_req = 0;
    if (!m_loaded[sel] || k != m_key[sel]) begin
      m_key[sel] = k; m_ctr[sel] = '0; m_exh[sel] = 0;
    end
    m_loaded[sel] = 1;
    @(negedge clk);
    total++;
    if (o_ctr !== m_ctr[sel] || o_exh !== m_exh[sel]) begin
      bad++; $display("FAIL key_load ctr/exh got=%h/%b exp=%h/%b", o_ctr, o_exh, m_ctr[sel], m_exh[sel]);
    end
    tick();
  endtask

  task automatic run_block(input int dly, input int hold);
    logic [127:0] exp_n, dout;
    blk_req = 1;
    @(negedge clk);
    total++;
    if (o_blk_gnt !== 1'b1) begin
      bad++; $display("FAIL blk_gnt got=%b exp=1", o_blk_gnt);
    end
    tick();
    blk_req = 0;
    exp_n = exp_nonce();
    @(negedge clk);
    total++;
    if (o_aes_start !== 1'b1 || o_aes_nonce !== exp_n || o_blk_gnt !== 1'b0) begin
      bad++; $display("FAIL start_nonce got=%b %h exp=1 %h", o_aes_start, o_aes_nonce, exp_n);
    end
    tick();
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      total++;
      if ({o_aes_start, o_ks_valid, o_err} !== 3'b000) begin
        bad++; $display("FAIL wait_quiet got=%b exp=000", {o_aes_start, o_ks_valid, o_err});
      end
      tick();
    end
    dout = rnd128();
    aes_done = 1; aes_dout = dout;
    tick();
    aes_done = 0; aes_dout = rnd128();
    if (m_ctr[sel] == m_max()) m_exh[sel] = 1;
    else                       m_ctr[sel] = m_ctr[sel] + 64'd1;
    @(negedge clk);
    total++;
    if (o_ks_valid !== 1'b1 || o_ks_data !== dout) begin
      bad++; $display("FAIL ks_out got=%b %h exp=1 %h", o_ks_valid, o_ks_data, dout);
    end
    total++;
    if (o_ctr !== m_ctr[sel] || o_exh !== m_exh[sel]) begin
      bad++; $display("FAIL ctr_update got=%h/%b exp=%h/%b", o_ctr, o_exh, m_ctr[sel], m_exh[sel]);
    end
    tick();
    for (int i = 0; i < hold; i++) begin
      ks_ready = 0; key_valid = 1; key_in = rnd128(); blk_req = 1; aes_done = 1; aes_dout = rnd128();
      @(negedge clk);
      total++;
      if (o_ks_valid !== 1'b1 || o_ks_data !== dout || o_key_ready !== 1'b0 || o_blk_gnt !== 1'b0) begin
        bad++; $display("FAIL hold_stable got=%b %h rdy=%b gnt=%b exp=1 %h", o_ks_valid, o_ks_data, o_key_ready, o_blk_gnt, dout);
      end
      tick();
    end
    key_valid = 0; blk_req = 0; aes_done = 0; ks_ready = 1;
    @(negedge clk);
    total++;
    if (o_ks_valid !== 1'b1 || o_ks_data !== dout) begin
      bad++; $display("FAIL handshake_cycle got=%b %h exp=1 %h", o_ks_valid, o_ks_data, dout);
    end
    tick();
    ks_ready = 0;
    @(negedge clk);
    total++;
    if (o_ks_valid !== 1'b0 || o_key_ready !== 1'b1) begin
      bad++; $display("FAIL back_to_idle got vld=%b rdy=%b exp vld=0 rdy=1", o_ks_valid, o_key_ready);
    end
    tick();
  endtask

  task automatic test_first_block();
    sel = 0;
    load_key(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    run_block(MAXD, 0);
  endtask

  task automatic test_same_key_reload();
    run_block($urandom_range(MAXD, 0), 0);
    run_block($urandom_range(MAXD, 0), $urandom_range(3, 0));
    load_key(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    run_block(1, 0);
  endtask

  task automatic test_key_change();
    load_key(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_block(0, 1);
  endtask

  task automatic test_backpressure();
    run_block(2, 5);
    load_key(m_key[sel]);
    run_block(3, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(3, 0) == 0)
        load_key(($urandom_range(1, 0) == 0) ? m_key[sel] : rnd128());
      run_block($urandom_range(MAXD, 0), $urandom_range(4, 0));
    end
  endtask

  task automatic test_idle_ignores();
    sel = 0;
    aes_done = 1; aes_dout = rnd128();
    tick();
    aes_done = 0;
    @(negedge clk);
    total++;
    if (o_ks_valid !== 1'b0 || o_ctr !== m_ctr[0]) begin
      bad++; $display("FAIL idle_done_ignored got vld=%b ctr=%h exp 0 %h", o_ks_valid, o_ctr, m_ctr[0]);
    end
    tick();
    sel = 1;
    blk_req = 1;
    @(negedge clk);
    total++;
    if (o_blk_gnt !== 1'b0) begin
      bad++; $display("FAIL no_key_gnt got=%b exp=0", o_blk_gnt);
    end
    tick();
    blk_req = 0;
    tick();
  endtask

  task automatic test_exhaust();
    sel = 1;
    load_key(rnd128());
    for (int n = 0; n < 16; n++) run_block($urandom_range(2, 0), 0);
    total++;
    if (o_exh !== 1'b1 || o_ctr !== 64'hF) begin
      bad++; $display("FAIL exhausted_state got=%b/%h exp=1/f", o_exh, o_ctr);
    end
    blk_req = 1;
    @(negedge clk);
    total++;
    if (o_blk_gnt !== 1'b0) begin
      bad++; $display("FAIL exhausted_gnt got=%b exp=0", o_blk_gnt);
    end
    tick();
    blk_req = 0;
    @(negedge clk);
    total++;
    if (o_aes_start !== 1'b0) begin
      bad++; $display("FAIL exhausted_start got=%b exp=0", o_aes_start);
    end
    tick();
    load_key(m_key[1] ^ 128'h1);
    run_block(1, 0);
    sel = 0;
  endtask

`ifdef NONCE_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] c0;
    sel = 0;
    c0 = m_ctr[0];
    blk_req = 1;
    tick();
    blk_req = 0;
    tick();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      total++;
      if (o_err !== 1'b0) begin
        bad++; $display("FAIL early_err cycle=%0d got=%b exp=0", i, o_err);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (o_err !== 1'b1 || o_ctr !== c0 || o_ks_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_err got err=%b ctr=%h vld=%b exp 1 %h 0", o_err, o_ctr, o_ks_valid, c0);
    end
    tick();
    aes_done = 1; aes_dout = rnd128();
    tick();
    aes_done = 0;
    @(negedge clk);
    total++;
    if (o_err !== 1'b0 || o_ks_valid !== 1'b0) begin
      bad++; $display("FAIL late_done got err=%b vld=%b exp 0 0", o_err, o_ks_valid);
    end
    tick();
    run_block(2, 0);
  endtask
`else
  task automatic test_long_wait();
    sel = 0;
    run_block(20, 1);
  endtask
`endif

  task automatic test_reset_mid_wait();
    sel = 0;
    blk_req = 1;
    tick();
    blk_req = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({w_key_ready, w_blk_gnt, w_aes_start, w_aes_nonce, w_ks_valid, w_ks_data, w_ctr, w_exh, w_err} !== '0) begin
      bad++; $display("FAIL mid_wait_reset got nonce=%h ctr=%h exp 0", w_aes_nonce, w_ctr);
    end
    total++;
    if ({n_key_ready, n_aes_nonce, n_ks_data, n_ctr, n_exh} !== '0) begin
      bad++; $display("FAIL mid_wait_reset_narrow got nonce=%h ctr=%h exp 0", n_aes_nonce, n_ctr);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    tick();
    load_key(rnd128());
    run_block(1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_block();
    test_same_key_reload();
    test_key_change();
    test_backpressure();
    test_random();
    test_idle_ignores();
    test_exhaust();
`ifdef NONCE_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctr_block_sequencer.md
Name: ctr_block_sequencer

Overview:
- Controller that sequences the CTR-mode keystream path: owns the session key and the 64-bit block counter, and forms each nonce as {IV, counter}.
- Launches the AES core with that nonce and returns the encrypted counter block to the consumer over a valid/ready handshake.
- Sits between the session/key interface and the AES round core. Enforces the counter policy: reset on key change, retain on same-key reload, never reuse a nonce.

Parameters:
- IV, 64'hba23890ace346bf1, fixed nonce prefix, upper 128-CTR_W bits of nonce (low bits of IV used).
- CTR_W, 64, counter width; reduced in test to exercise wrap.
- TIMEOUT, 64, max cycles in WAIT before abort (only with NONCE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- key_valid  in  1  key load request.
- key_in  in  128  session key.
- key_ready  out  1  high only in IDLE.
- blk_req  in  1  request one keystream block.
- blk_gnt  out  1  one-cycle pulse: request accepted.
- aes_start  out  1  one-cycle start pulse to AES core.
- aes_nonce  out  128  counter block driven to AES core.
- aes_done  in  1  AES core result valid (single-cycle).
- aes_dout  in  128  AES core result.
- ks_valid  out  1  keystream block valid.
- ks_data  out  128  keystream block.
- ks_ready  in  1  consumer accepts keystream.
- ctr_value  out  CTR_W  current counter (next nonce to issue).
- exhausted  out  1  counter space used up for this key.
- err  out  1  timeout abort pulse (0 without macro).

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, stored key 0, key_loaded 0, counter 0.
- States: IDLE, START, WAIT, HOLD.
- IDLE, key_valid=1:
  - key_valid has priority over blk_req.
  - If !key_loaded or key_in != stored key: store key_in, counter<=0, exhausted<=0, key_loaded<=1.
  - Else (same key): counter and exhausted are retained.
  - Takes one cycle; state stays IDLE; no blk_gnt that cycle.
- IDLE, blk_req=1, key_valid=0, key_loaded=1, exhausted=0:
  - blk_gnt pulses.
  - aes_nonce <= {IV, counter}.
  - Next state START.
- IDLE, blk_req with key_loaded=0 or exhausted=1: ignored. No blk_gnt, no state change.
- START: aes_start=1 for exactly one cycle, then WAIT.
- WAIT, aes_done=1:
  - ks_data <= aes_dout, ks_valid<=1, next state HOLD.
  - Counter update: if counter == all-ones, counter holds at all-ones and exhausted<=1. Otherwise counter<=counter+1.
- HOLD: ks_valid and ks_data held stable until ks_ready=1. On the handshake cycle, ks_valid<=0 and next state IDLE.
- Latency:
  - blk_gnt at cycle T, aes_start at T+1.
  - aes_done at cycle D gives ks_valid at D+1.
  - Minimum turnaround back to IDLE: one cycle after the ks handshake.
- aes_done outside WAIT is ignored.
- key_valid outside IDLE is ignored (key_ready=0); the key cannot change mid-block.
- aes_nonce holds the last issued value between blocks.
- Counter increments only on completion, never on grant, so an aborted block's nonce is reissued.

Optional Feature:
- Macro: NONCE_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles pass with no aes_done: err pulses one cycle, state returns to IDLE.
  - Counter is not incremented and ks_valid is not asserted.
  - A late aes_done is then ignored.
- Without the macro: WAIT is unbounded and err is tied 0.

Test Plan:
- Reset, then key_in=K1 with key_valid, then blk_req: blk_gnt, aes_nonce=128'hba23890ace346bf1_0000000000000000; aes_done after 10 cycles gives ks_data=aes_dout, ctr_value=1.
- Three blocks under K1, then reload K1 (same value): ctr_value stays 3; next aes_nonce low half = 3.
- Load K2 != K1 after 3 blocks: ctr_value=0, exhausted=0; next nonce low half = 0.
- CTR_W=4, 16 blocks: after the 16th, exhausted=1 and ctr_value=4'hF; a 17th blk_req gives no blk_gnt; loading a new key clears exhausted.
- ks_ready held 0 for 5 cycles after ks_valid: ks_data stable; key_valid and blk_req ignored; IDLE is entered the cycle after ks_ready=1.
- NONCE_TIMEOUT_EN, TIMEOUT=8, aes_done never asserted: err pulses 8 cycles after entering WAIT, ctr_value unchanged; reset asserted mid-WAIT returns all outputs to 0 immediately.
